// File: rtl/csr_unit_pkg.sv
// Shared CSR constants: addresses, field positions, reset values and WB bus widths.
// The stable timer is only built when CSR_TIMER_EN is defined.
package csr_unit_pkg;

   // Request bus widths as packed by the write-back stage
   localparam int CSR_ADDR_W     = 14;
   localparam int CSR_DATA_W     = 32;
   localparam int ECODE_W        = 6;
   localparam int ESUBCODE_W     = 9;
   localparam int WB_CSR_BUS_W   = 1 + CSR_ADDR_W + CSR_DATA_W;
   localparam int WB_LLBIT_BUS_W = 2;
   localparam int WB_EXCEP_BUS_W = 1 + ECODE_W + ESUBCODE_W + 32 + 1 + 32 + 1;

   localparam logic [CSR_ADDR_W-1:0] CSR_CRMD   = 14'h000;
   localparam logic [CSR_ADDR_W-1:0] CSR_PRMD   = 14'h001;
   localparam logic [CSR_ADDR_W-1:0] CSR_EUEN   = 14'h002;
   localparam logic [CSR_ADDR_W-1:0] CSR_ECFG   = 14'h004;
   localparam logic [CSR_ADDR_W-1:0] CSR_ESTAT  = 14'h005;
   localparam logic [CSR_ADDR_W-1:0] CSR_ERA    = 14'h006;
   localparam logic [CSR_ADDR_W-1:0] CSR_BADV   = 14'h007;
   localparam logic [CSR_ADDR_W-1:0] CSR_EENTRY = 14'h00C;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE0  = 14'h030;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE1  = 14'h031;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE2  = 14'h032;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE3  = 14'h033;
   localparam logic [CSR_ADDR_W-1:0] CSR_TID    = 14'h040;
   localparam logic [CSR_ADDR_W-1:0] CSR_TCFG   = 14'h041;
   localparam logic [CSR_ADDR_W-1:0] CSR_TVAL   = 14'h042;
   localparam logic [CSR_ADDR_W-1:0] CSR_TICLR  = 14'h044;
   localparam logic [CSR_ADDR_W-1:0] CSR_LLBCTL = 14'h060;

   localparam int CRMD_PLV_LO    = 0;
   localparam int CRMD_PLV_HI    = 1;
   localparam int CRMD_IE        = 2;
   localparam int ESTAT_IS_HI    = 12;
   localparam int ESTAT_TI       = 11;
   localparam int ESTAT_HWI_LO   = 2;
   localparam int ESTAT_ECODE_LO = 16;
   localparam int ESTAT_ESUB_LO  = 22;
   localparam int LLBCTL_WCLLB   = 1;
   localparam int LLBCTL_KLO     = 2;
   localparam int TCFG_EN        = 0;
   localparam int TCFG_PERIODIC  = 1;
   localparam int TCFG_INITV_LO  = 2;

   localparam logic [4:0]  CRMD_RST      = 5'h08;
   localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

endpackage

// File: rtl/csr_unit_timer.sv
// Stable timer: TCFG/TVAL and the IS[11] timer interrupt latch, present only with CSR_TIMER_EN.
// Without the macro all outputs are tied to 0 and the inputs are ignored.
module csr_timer
   import csr_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tcfg_we,
   input  logic [31:0] i_tcfg_wdata,
   input  logic        i_ticlr_clr,
   output logic [31:0] o_tcfg,
   output logic [31:0] o_tval,
   output logic        o_timer_int
);

`ifdef CSR_TIMER_EN
   logic [31:0] r_tcfg;
   logic [31:0] r_tval;
   logic        r_timer_int;
   logic        w_fire;

   // A TCFG write in the same cycle pre-empts the 1->0 step entirely
   assign w_fire = ~i_tcfg_we & r_tcfg[TCFG_EN] & (r_tval == 32'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcfg <= '0;
         r_tval <= '0;
      end else if (i_tcfg_we) begin
         r_tcfg <= i_tcfg_wdata;
         r_tval <= {i_tcfg_wdata[31:TCFG_INITV_LO], 2'b00};
      end else if (r_tcfg[TCFG_EN] && (r_tval != 32'd0)) begin
         if (r_tval == 32'd1)
            r_tval <= r_tcfg[TCFG_PERIODIC] ? {r_tcfg[31:TCFG_INITV_LO], 2'b00} : 32'd0;
         else
            r_tval <= r_tval - 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_timer_int <= 1'b0;
      else if (w_fire)
         r_timer_int <= 1'b1;
      else if (i_ticlr_clr)
         r_timer_int <= 1'b0;
   end

   assign o_tcfg      = r_tcfg;
   assign o_tval      = r_tval;
   assign o_timer_int = r_timer_int;
`else
   logic w_unused;
   assign w_unused    = ^{clk, rst, i_tcfg_we, i_tcfg_wdata, i_ticlr_clr};
   assign o_tcfg      = '0;
   assign o_tval      = '0;
   assign o_timer_int = 1'b0;
`endif

endmodule

// File: rtl/csr_unit.sv
// LoongArch CSR file: architectural CSRs, exception entry/ertn commit, LLbit and interrupt pending.
// Define CSR_TIMER_EN to build the stable timer (TCFG/TVAL/TICLR, IS[11]); otherwise those read 0.
module csr_unit
   import csr_unit_pkg::*;
#(
   parameter logic [31:0] COREID = 32'h0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] csr_raddr_i,
   input  logic        csr_we_i,
   input  logic [13:0] csr_waddr_i,
   input  logic [31:0] csr_wdata_i,
   input  logic        llbit_we_i,
   input  logic        llbit_wdata_i,
   input  logic        excep_en_i,
   input  logic [5:0]  excep_ecode_i,
   input  logic [8:0]  excep_esubcode_i,
   input  logic [31:0] excep_pc_i,
   input  logic        badv_we_i,
   input  logic [31:0] badv_wdata_i,
   input  logic        ertn_en_i,
   input  logic [7:0]  hw_int_i,
   output logic [31:0] csr_rdata_o,
   output logic [1:0]  cpu_level_o,
   output logic [31:0] eentry_pc_o,
   output logic [31:0] era_pc_o,
   output logic        int_pending_o,
   output logic        llbit_o
);

   logic [4:0]  r_crmd;
   logic [2:0]  r_prmd;
   logic        r_euen;
   logic [12:0] r_ecfg_lie;
   logic [1:0]  r_estat_sw;
   logic [7:0]  r_estat_hw;
   logic [5:0]  r_ecode;
   logic [8:0]  r_esubcode;
   logic [31:0] r_era;
   logic [31:0] r_badv;
   logic [25:0] r_eentry;
   logic [31:0] r_save [0:3];
   logic [31:0] r_tid;
   logic        r_llbit;
   logic        r_klo;

   logic        w_excep;
   logic        w_ertn;
   logic        w_wr;
   logic        w_tcfg_we;
   logic        w_ticlr_clr;
   logic [31:0] w_tcfg;
   logic [31:0] w_tval;
   logic        w_timer_int;
   logic [12:0] w_is;
   logic [31:0] w_rdata;

   // Exception beats ertn, and either one suppresses the plain CSR write
   assign w_excep = excep_en_i;
   assign w_ertn  = ertn_en_i & ~excep_en_i;
   assign w_wr    = csr_we_i & ~excep_en_i & ~ertn_en_i;

   assign w_tcfg_we   = w_wr & (csr_waddr_i == CSR_TCFG);
   assign w_ticlr_clr = w_wr & (csr_waddr_i == CSR_TICLR) & csr_wdata_i[0];

   csr_timer u_timer (
      .clk          (clk),
      .rst          (rst),
      .i_tcfg_we    (w_tcfg_we),
      .i_tcfg_wdata (csr_wdata_i),
      .i_ticlr_clr  (w_ticlr_clr),
      .o_tcfg       (w_tcfg),
      .o_tval       (w_tval),
      .o_timer_int  (w_timer_int)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_crmd <= CRMD_RST;
         r_prmd <= '0;
      end else if (w_excep) begin
         r_prmd                           <= {r_crmd[CRMD_IE], r_crmd[CRMD_PLV_HI:CRMD_PLV_LO]};
         r_crmd[CRMD_IE:CRMD_PLV_LO]      <= 3'b000;
      end else if (w_ertn) begin
         r_crmd[CRMD_IE:CRMD_PLV_LO]      <= r_prmd;
      end else if (w_wr) begin
         if (csr_waddr_i == CSR_CRMD)
            r_crmd <= csr_wdata_i[4:0];
         if (csr_waddr_i == CSR_PRMD)
            r_prmd <= csr_wdata_i[2:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estat_sw <= '0;
         r_estat_hw <= '0;
         r_ecode    <= '0;
         r_esubcode <= '0;
      end else begin
         r_estat_hw <= hw_int_i;
         if (w_excep) begin
            r_ecode    <= excep_ecode_i;
            r_esubcode <= excep_esubcode_i;
         end else if (w_wr && (csr_waddr_i == CSR_ESTAT)) begin
            r_estat_sw <= csr_wdata_i[1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_era  <= '0;
         r_badv <= '0;
      end else if (w_excep) begin
         r_era <= excep_pc_i;
         if (badv_we_i)
            r_badv <= badv_wdata_i;
      end else if (w_wr) begin
         if (csr_waddr_i == CSR_ERA)
            r_era <= csr_wdata_i;
         if (csr_waddr_i == CSR_BADV)
            r_badv <= csr_wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_euen     <= 1'b0;
         r_ecfg_lie <= '0;
         r_eentry   <= '0;
         r_tid      <= COREID;
         r_save[0]  <= '0;
         r_save[1]  <= '0;
         r_save[2]  <= '0;
         r_save[3]  <= '0;
      end else if (w_wr) begin
         case (csr_waddr_i)
            CSR_EUEN:   r_euen     <= csr_wdata_i[0];
            CSR_ECFG:   r_ecfg_lie <= csr_wdata_i[12:0] & ECFG_LIE_MASK;
            CSR_EENTRY: r_eentry   <= csr_wdata_i[31:6];
            CSR_SAVE0:  r_save[0]  <= csr_wdata_i;
            CSR_SAVE1:  r_save[1]  <= csr_wdata_i;
            CSR_SAVE2:  r_save[2]  <= csr_wdata_i;
            CSR_SAVE3:  r_save[3]  <= csr_wdata_i;
            CSR_TID:    r_tid      <= csr_wdata_i;
            default: ;
         endcase
      end
   end

   // ll/sc updates outrank both the ertn clear and a WCLLB write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_llbit <= 1'b0;
         r_klo   <= 1'b0;
      end else begin
         if (llbit_we_i)
            r_llbit <= llbit_wdata_i;
         else if (w_ertn && !r_klo)
            r_llbit <= 1'b0;
         else if (w_wr && (csr_waddr_i == CSR_LLBCTL) && csr_wdata_i[LLBCTL_WCLLB])
            r_llbit <= 1'b0;

         if (w_ertn)
            r_klo <= 1'b0;
         else if (w_wr && (csr_waddr_i == CSR_LLBCTL))
            r_klo <= csr_wdata_i[LLBCTL_KLO];
      end
   end

   assign w_is = {1'b0, w_timer_int, 1'b0, r_estat_hw, r_estat_sw};

   always_comb begin
      w_rdata = '0;
      case (csr_raddr_i)
         CSR_CRMD:   w_rdata = {27'b0, r_crmd};
         CSR_PRMD:   w_rdata = {29'b0, r_prmd};
         CSR_EUEN:   w_rdata = {31'b0, r_euen};
         CSR_ECFG:   w_rdata = {19'b0, r_ecfg_lie};
         CSR_ESTAT:  w_rdata = {1'b0, r_esubcode, r_ecode, 3'b0, w_is};
         CSR_ERA:    w_rdata = r_era;
         CSR_BADV:   w_rdata = r_badv;
         CSR_EENTRY: w_rdata = {r_eentry, 6'b0};
         CSR_SAVE0:  w_rdata = r_save[0];
         CSR_SAVE1:  w_rdata = r_save[1];
         CSR_SAVE2:  w_rdata = r_save[2];
         CSR_SAVE3:  w_rdata = r_save[3];
         CSR_TID:    w_rdata = r_tid;
         CSR_TCFG:   w_rdata = w_tcfg;
         CSR_TVAL:   w_rdata = w_tval;
         CSR_LLBCTL: w_rdata = {29'b0, r_klo, 1'b0, r_llbit};
         default:    w_rdata = '0;
      endcase
   end

   assign csr_rdata_o   = w_rdata;
   assign cpu_level_o   = r_crmd[CRMD_PLV_HI:CRMD_PLV_LO];
   assign eentry_pc_o   = {r_eentry, 6'b0};
   assign era_pc_o      = r_era;
   assign int_pending_o = r_crmd[CRMD_IE] & (|(w_is & r_ecfg_lie));
   assign llbit_o       = r_llbit;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a word-level model of the CSR file.
module tb_csr_unit;

   localparam logic [31:0] CORE = 32'h0000_005A;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [13:0] csr_raddr_i = '0;
   logic        csr_we_i = 1'b0;
   logic [13:0] csr_waddr_i = '0;
   logic [31:0] csr_wdata_i = '0;
   logic        llbit_we_i = 1'b0;
   logic        llbit_wdata_i = 1'b0;
   logic        excep_en_i = 1'b0;
   logic [5:0]  excep_ecode_i = '0;
   logic [8:0]  excep_esubcode_i = '0;
   logic [31:0] excep_pc_i = '0;
   logic        badv_we_i = 1'b0;
   logic [31:0] badv_wdata_i = '0;
   logic        ertn_en_i = 1'b0;
   logic [7:0]  hw_int_i = '0;
   logic [31:0] csr_rdata_o;
   logic [1:0]  cpu_level_o;
   logic [31:0] eentry_pc_o;
   logic [31:0] era_pc_o;
   logic        int_pending_o;
   logic        llbit_o;

   csr_unit #(.COREID(CORE)) dut (
      .clk(clk), .rst(rst),
      .csr_raddr_i(csr_raddr_i), .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
      .llbit_we_i(llbit_we_i), .llbit_wdata_i(llbit_wdata_i),
      .excep_en_i(excep_en_i), .excep_ecode_i(excep_ecode_i), .excep_esubcode_i(excep_esubcode_i),
      .excep_pc_i(excep_pc_i), .badv_we_i(badv_we_i), .badv_wdata_i(badv_wdata_i),
      .ertn_en_i(ertn_en_i), .hw_int_i(hw_int_i),
      .csr_rdata_o(csr_rdata_o), .cpu_level_o(cpu_level_o), .eentry_pc_o(eentry_pc_o),
      .era_pc_o(era_pc_o), .int_pending_o(int_pending_o), .llbit_o(llbit_o)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Architectural state held as whole 32-bit CSR words
   logic [31:0] m_crmd, m_prmd, m_euen, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
   logic [31:0] m_save [4];
   logic [7:0]  m_hw;
   logic        m_ti, m_llbit, m_klo;

   logic [13:0] addrs [19] = '{14'h000, 14'h001, 14'h002, 14'h004, 14'h005, 14'h006, 14'h007, 14'h00C,
                               14'h030, 14'h031, 14'h032, 14'h033, 14'h040, 14'h041, 14'h042, 14'h044,
                               14'h060, 14'h003, 14'h061};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] wm(input logic [31:0] o, input logic [31:0] d, input logic [31:0] m);
      return (o & ~m) | (d & m);
   endfunction

   function automatic logic [31:0] m_is();
      return (m_estat & 32'h3) | ({24'b0, m_hw} << 2) | ({31'b0, m_ti} << 11);
   endfunction

   function automatic logic [31:0] m_read(input logic [13:0] a);
      case (a)
         14'h000: return m_crmd;
         14'h001: return m_prmd;
         14'h002: return m_euen;
         14'h004: return m_ecfg;
         14'h005: return (m_estat & 32'h7FFF_0000) | m_is();
         14'h006: return m_era;
         14'h007: return m_badv;
         14'h00C: return m_eentry;
         14'h030: return m_save[0];
         14'h031: return m_save[1];
         14'h032: return m_save[2];
         14'h033: return m_save[3];
         14'h040: return m_tid;
`ifdef CSR_TIMER_EN
         14'h041: return m_tcfg;
         14'h042: return m_tval;
`endif
         14'h060: return {29'b0, m_klo, 1'b0, m_llbit};
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_crmd = 32'h8; m_prmd = 0; m_euen = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
      m_eentry = 0; m_tid = CORE; m_tcfg = 0; m_tval = 0; m_hw = 0; m_ti = 0; m_llbit = 0; m_klo = 0;
      for (int i = 0; i < 4; i++) m_save[i] = 0;
   endtask

   // Next architectural state from the inputs about to be clocked in
   task automatic m_step();
      logic exc, ert, wr, fire;
      logic [13:0] a;
      logic [31:0] d;
      logic [31:0] n_crmd, n_prmd, n_euen, n_ecfg, n_estat, n_era, n_badv, n_eentry, n_tid, n_tcfg, n_tval;
      logic [31:0] n_save [4];
      logic n_ti, n_llbit, n_klo;
      n_crmd = m_crmd; n_prmd = m_prmd; n_euen = m_euen; n_ecfg = m_ecfg; n_estat = m_estat;
      n_era = m_era; n_badv = m_badv; n_eentry = m_eentry; n_tid = m_tid; n_tcfg = m_tcfg;
      n_tval = m_tval; n_ti = m_ti; n_llbit = m_llbit; n_klo = m_klo;
      for (int i = 0; i < 4; i++) n_save[i] = m_save[i];
      exc = excep_en_i;
      ert = ertn_en_i && !exc;
      wr  = csr_we_i && !exc && !ertn_en_i;
      a = csr_waddr_i;
      d = csr_wdata_i;
      if (exc) begin
         n_prmd  = (m_prmd & ~32'h7) | (m_crmd & 32'h7);
         n_crmd  = m_crmd & ~32'h7;
         n_era   = excep_pc_i;
         n_estat = (m_estat & ~32'h7FFF_0000) | ({17'b0, excep_esubcode_i, excep_ecode_i} << 16);
         if (badv_we_i) n_badv = badv_wdata_i;
      end else if (ert) begin
         n_crmd = (m_crmd & ~32'h7) | (m_prmd & 32'h7);
         n_klo  = 1'b0;
      end else if (wr) begin
         case (a)
            14'h000: n_crmd   = wm(m_crmd, d, 32'h1F);
            14'h001: n_prmd   = wm(m_prmd, d, 32'h7);
            14'h002: n_euen   = wm(m_euen, d, 32'h1);
            14'h004: n_ecfg   = wm(m_ecfg, d, 32'h1BFF);
            14'h005: n_estat  = wm(m_estat, d, 32'h3);
            14'h006: n_era    = d;
            14'h007: n_badv   = d;
            14'h00C: n_eentry = wm(m_eentry, d, 32'hFFFF_FFC0);
            14'h030, 14'h031, 14'h032, 14'h033: n_save[a - 14'h030] = d;
            14'h040: n_tid    = d;
            14'h060: n_klo    = d[2];
            default: ;
         endcase
      end
      if (llbit_we_i) n_llbit = llbit_wdata_i;
      else if (ert && !m_klo) n_llbit = 1'b0;
      else if (wr && a == 14'h060 && d[1]) n_llbit = 1'b0;
      fire = 1'b0;
`ifdef CSR_TIMER_EN
      if (wr && a == 14'h041) begin
         n_tcfg = d;
         n_tval = d & ~32'h3;
      end else if (m_tcfg[0] && m_tval != 0) begin
         if (m_tval == 1) begin
            fire = 1'b1;
            n_tval = m_tcfg[1] ? (m_tcfg & ~32'h3) : 32'h0;
         end else begin
            n_tval = m_tval - 1;
         end
      end
      if (fire) n_ti = 1'b1;
      else if (wr && a == 14'h044 && d[0]) n_ti = 1'b0;
`endif
      m_crmd = n_crmd; m_prmd = n_prmd; m_euen = n_euen; m_ecfg = n_ecfg; m_estat = n_estat;
      m_era = n_era; m_badv = n_badv; m_eentry = n_eentry; m_tid = n_tid; m_tcfg = n_tcfg;
      m_tval = n_tval; m_ti = n_ti; m_llbit = n_llbit; m_klo = n_klo; m_hw = hw_int_i;
      for (int i = 0; i < 4; i++) m_save[i] = n_save[i];
   endtask

   task automatic compare_all();
      chk("rdata", csr_rdata_o, m_read(csr_raddr_i));
      chk("cpu_level", {30'b0, cpu_level_o}, {30'b0, m_crmd[1:0]});
      chk("eentry_pc", eentry_pc_o, m_eentry & 32'hFFFF_FFC0);
      chk("era_pc", era_pc_o, m_era);
      chk("int_pending", {31'b0, int_pending_o}, {31'b0, m_crmd[2] & (|(m_is() & m_ecfg & 32'h1FFF))});
      chk("llbit", {31'b0, llbit_o}, {31'b0, m_llbit});
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      csr_we_i = 0; csr_waddr_i = 0; csr_wdata_i = 0; llbit_we_i = 0; llbit_wdata_i = 0;
      excep_en_i = 0; excep_ecode_i = 0; excep_esubcode_i = 0; excep_pc_i = 0;
      badv_we_i = 0; badv_wdata_i = 0; ertn_en_i = 0;
   endtask

   task automatic wr_csr(input logic [13:0] a, input logic [31:0] d);
      idle();
      csr_we_i = 1; csr_waddr_i = a; csr_wdata_i = d;
      tick();
      idle();
   endtask

   task automatic excep(input logic [31:0] pc, input logic bwe, input logic [31:0] bv);
      idle();
      excep_en_i = 1; excep_ecode_i = 6'hB; excep_pc_i = pc; badv_we_i = bwe; badv_wdata_i = bv;
      tick();
      idle();
   endtask

   task automatic peek(input string n, input logic [13:0] a, input logic [31:0] exp);
      csr_raddr_i = a;
      #1;
      chk(n, csr_rdata_o, exp);
   endtask

   task automatic peek_is11(input string n, input logic exp);
      csr_raddr_i = 14'h005;
      #1;
      chk(n, {31'b0, csr_rdata_o[11]}, {31'b0, exp});
   endtask

   task automatic reset_checks();
      peek("rst_crmd", 14'h000, 32'h8);
      peek("rst_tid", 14'h040, CORE);
      peek("rst_era", 14'h006, 32'h0);
      chk("rst_plv", {30'b0, cpu_level_o}, 32'h0);
      chk("rst_intp", {31'b0, int_pending_o}, 32'h0);
      chk("rst_llbit", {31'b0, llbit_o}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      // Reset asserted between clock edges must act immediately
      #3 rst = 1'b1;
      reset_checks();
      @(negedge clk);
      rst = 1'b0;
      m_reset();

      wr_csr(14'h000, 32'h7);
      peek("crmd_set", 14'h000, 32'h7);
      wr_csr(14'h00C, 32'h1C00_807F);
      chk("eentry_mask", eentry_pc_o, 32'h1C00_8040);

      excep(32'h1C00_0100, 1'b0, 32'h0);
      peek("exc_crmd", 14'h000, 32'h0);
      peek("exc_prmd", 14'h001, 32'h7);
      peek("exc_era", 14'h006, 32'h1C00_0100);
      peek("exc_estat", 14'h005, 32'h000B_0000);
      chk("exc_era_pc", era_pc_o, 32'h1C00_0100);
      ertn_en_i = 1;
      tick();
      idle();
      peek("ertn_crmd", 14'h000, 32'h7);

      excep(32'h1C00_0200, 1'b1, 32'h3);
      peek("badv_we", 14'h007, 32'h3);
      excep(32'h1C00_0300, 1'b0, 32'h55);
      peek("badv_keep", 14'h007, 32'h3);

      wr_csr(14'h030, 32'h1234);
      excep_en_i = 1; excep_ecode_i = 6'hB; csr_we_i = 1; csr_waddr_i = 14'h030; csr_wdata_i = 32'hDEAD;
      tick();
      idle();
      peek("prio_save0", 14'h030, 32'h1234);

      llbit_we_i = 1; llbit_wdata_i = 1;
      tick();
      idle();
      peek("ll_set", 14'h060, 32'h1);
      wr_csr(14'h060, 32'h2);
      peek("ll_wcllb", 14'h060, 32'h0);
      llbit_we_i = 1; llbit_wdata_i = 1;
      tick();
      wr_csr(14'h060, 32'h4);
      peek("ll_klo", 14'h060, 32'h5);
      ertn_en_i = 1;
      tick();
      idle();
      peek("ll_ertn_klo", 14'h060, 32'h1);

      wr_csr(14'h000, 32'h4);
      wr_csr(14'h004, 32'h800);
`ifdef CSR_TIMER_EN
      wr_csr(14'h041, 32'hB);
      peek("tval_load", 14'h042, 32'h8);
      for (int i = 0; i < 7; i++) tick();
      peek("tval_one", 14'h042, 32'h1);
      peek_is11("ti_not_yet", 1'b0);
      tick();
      peek("tval_reload", 14'h042, 32'h8);
      peek_is11("ti_fire", 1'b1);
      chk("ti_intp", {31'b0, int_pending_o}, 32'h1);
      wr_csr(14'h044, 32'h1);
      peek_is11("ti_clear", 1'b0);
      chk("ti_intp_clr", {31'b0, int_pending_o}, 32'h0);
      wr_csr(14'h041, 32'h5);
      peek("tval_oneshot", 14'h042, 32'h4);
      for (int i = 0; i < 3; i++) tick();
      wr_csr(14'h044, 32'h1);
      peek_is11("ti_set_wins", 1'b1);
      peek("tval_hold0", 14'h042, 32'h0);
      tick();
      peek("tval_stay0", 14'h042, 32'h0);
      wr_csr(14'h044, 32'h1);
      peek_is11("ti_clear2", 1'b0);
`else
      wr_csr(14'h041, 32'hB);
      peek("tcfg_absent", 14'h041, 32'h0);
      peek("tval_absent", 14'h042, 32'h0);
      for (int i = 0; i < 8; i++) tick();
      peek_is11("ti_absent", 1'b0);
      chk("intp_absent", {31'b0, int_pending_o}, 32'h0);
`endif

      for (int n = 0; n < 4000; n++) begin
         csr_we_i         = ($urandom_range(0, 1) == 1);
         csr_waddr_i      = ($urandom_range(0, 15) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 18)];
         d                = $urandom;
         if (csr_waddr_i == 14'h041)
            d = (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
         csr_wdata_i      = d;
         excep_en_i       = ($urandom_range(0, 15) == 0);
         ertn_en_i        = ($urandom_range(0, 15) == 0);
         excep_ecode_i    = 6'($urandom);
         excep_esubcode_i = 9'($urandom);
         excep_pc_i       = $urandom;
         badv_we_i        = ($urandom_range(0, 1) == 1);
         badv_wdata_i     = $urandom;
         llbit_we_i       = ($urandom_range(0, 7) == 0);
         llbit_wdata_i    = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 7) == 0) hw_int_i = 8'($urandom);
         csr_raddr_i      = ($urandom_range(0, 15) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 18)];
         tick();
         if (n == 2000) begin
            // Reset with an exception and a write pending: neither may land
            idle();
            excep_en_i = 1; excep_pc_i = 32'hCAFE_0000; csr_we_i = 1; csr_waddr_i = 14'h030; csr_wdata_i = 32'h1;
            #3 rst = 1'b1;
            reset_checks();
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            idle();
            hw_int_i = 0;
            m_reset();
            #1;
            compare_all();
            peek("rst_save0", 14'h030, 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
